// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact occupancy count, almost-full/almost-empty flags,
// and optional sticky overflow/underflow flags (enabled by SYNC_FIFO_FLAGS_ERR_EN).
module sync_fifo_flags #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_C = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AF_C    = AF_THRESH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AE_C    = AE_THRESH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] ONE_C   = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wptr;
    logic [PTR_WIDTH:0]    rptr;
    logic [PTR_WIDTH:0]    count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come only from the registered count, so requests never reach outputs combinationally.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = w_en & ~full;
    assign rd_acc = r_en & ~empty;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wptr[PTR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE_C;
            end
            if (rd_acc) begin
                data_out <= mem[rptr[PTR_WIDTH-1:0]];
                rptr     <= rptr + ONE_C;
            end
            count <= count_nxt;
        end
    end

`ifdef SYNC_FIFO_FLAGS_ERR_EN
    // Set has priority over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: a reference queue/count model is stepped
// alongside the DUT each cycle and every output is compared after the edge.
module tb_sync_fifo_flags;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          err_clr = 1'b0;
    logic          overflow, underflow;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [DW-1:0] sb_q[$];
    int            m_count = 0;
    logic [DW-1:0] m_dout  = '0;
    logic          m_ovf   = 1'b0;
    logic          m_udf   = 1'b0;

    sync_fifo_flags #(
        .DEPTH     (DEPTH),
        .DATA_WIDTH(DW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_en        (w_en),
        .r_en        (r_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .err_clr     (err_clr),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":count"}, 32'(count), 32'(m_count));
        check({tag, ":empty"}, 32'(empty), 32'(m_count == 0));
        check({tag, ":full"}, 32'(full), 32'(m_count == DEPTH));
        check({tag, ":af"}, 32'(almost_full), 32'(m_count >= AF));
        check({tag, ":ae"}, 32'(almost_empty), 32'(m_count <= AE));
        check({tag, ":dout"}, 32'(data_out), 32'(m_dout));
`ifdef SYNC_FIFO_FLAGS_ERR_EN
        check({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ":udf"}, 32'(underflow), 32'(m_udf));
`else
        check({tag, ":ovf"}, 32'(overflow), 32'd0);
        check({tag, ":udf"}, 32'(underflow), 32'd0);
`endif
    endtask

    task automatic step(input string tag, input logic we, input logic re,
                        input logic [DW-1:0] din, input logic clr);
        logic wa, ra;
        w_en    = we;
        r_en    = re;
        data_in = din;
        err_clr = clr;
        wa = we && (m_count != DEPTH);
        ra = re && (m_count != 0);
        if (ra) begin
            m_dout = sb_q.pop_front();
            m_count--;
        end
        if (wa) begin
            sb_q.push_back(din);
            m_count++;
        end
        if (we && !wa)      m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (re && !ra)      m_udf = 1'b1;
        else if (clr)       m_udf = 1'b0;
        @(posedge clk);
        #1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        err_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        m_count = 0;
        m_dout  = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        check_all("reset");
    endtask

    initial begin
        do_reset();

        for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0, 1'b0);

        for (int i = 0; i < 8; i++) step("fill2", 1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        step("full_rw", 1'b1, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 7; i++) step("drain2", 1'b0, 1'b1, '0, 1'b0);
        step("empty_rw", 1'b1, 1'b1, 8'h5C, 1'b0);
        step("read_5c", 1'b0, 1'b1, '0, 1'b0);

        step("clr", 1'b0, 1'b0, '0, 1'b1);
        step("udf_set", 1'b0, 1'b1, '0, 1'b0);
        step("clr2", 1'b0, 1'b0, '0, 1'b1);
        step("set_vs_clr", 1'b0, 1'b1, '0, 1'b1);
        step("clr3", 1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 4; i++) step("pre4", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) step("steady", 1'b1, 1'b1, 8'(8'h44 + i), 1'b0);
        for (int i = 0; i < 4; i++) step("post4", 1'b0, 1'b1, '0, 1'b0);

        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        step("pre_rst_rd", 1'b0, 1'b1, '0, 1'b0);
        do_reset();
        step("post_rst_w", 1'b1, 1'b0, 8'h33, 1'b0);
        step("post_rst_r", 1'b0, 1'b1, '0, 1'b0);

        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 7) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
